// File: rtl/i2c_slave_link.sv
// ---------------------------------------------------------------------------
// i2c_slave_link
//
// This module is an I2C slave front end that connects an I2C bus to a simple
// byte-wide register memory. The master first writes a register pointer.
// After that it either writes data bytes or issues a repeated START and reads
// data bytes back. The memory steps its own byte index during a burst, so the
// pointer presented here stays fixed for the whole burst.
//
// Ports
//   Clk             system clock; every register updates on its rising edge
//   Reset           synchronous, active-high reset
//   SclIn, SdaIn    raw bus lines; they are asynchronous to Clk
//   SdaOe           1 = pull SDA low, 0 = release it (open-drain)
//   Enable          one-Clk transfer strobe to the memory
//   RorW            1 = write InputBuffer to memory, 0 = read into OutputBuffer
//   DirectionBuffer register pointer presented to the memory
//   InputBuffer     byte to be written to the memory
//   OutputBuffer    byte returned by the memory for a read
//   AddressFound    memory reports that the pointer is valid
//   Busy            high from START until STOP (or until a return to idle)
// ---------------------------------------------------------------------------
module i2c_slave_link #(
  parameter logic [6:0] DEVADDR       = 7'h50,
  parameter int         ADDRESSLENGTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     SclIn,
  input  logic                     SdaIn,
  output logic                     SdaOe,
  output logic                     Enable,
  output logic                     RorW,
  output logic [ADDRESSLENGTH-1:0] DirectionBuffer,
  output logic [7:0]               InputBuffer,
  input  logic [7:0]               OutputBuffer,
  input  logic                     AddressFound,
  output logic                     Busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVADDR,
    S_DEVACK,
    S_PTR,
    S_PTRACK,
    S_WRDATA,
    S_WRACK,
    S_RDLOAD,
    S_RDDATA,
    S_RDACK,
    S_WAITSTOP
  } state_t;

  // -------------------------------------------------------------------------
  // Bus synchronizers: two flops per line, plus one history flop.
  // Bit 0 carries SCL and bit 1 carries SDA.
  // These flops reset to 1, which is the idle bus level. An idle bus
  // therefore produces no edge when reset is released.
  // -------------------------------------------------------------------------
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_hist;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_hist  <= 2'b11;
    end else begin
      r_sync1 <= {SdaIn, SclIn};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_prev;
  logic w_sda_prev;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_sync2[0];
  assign w_sda      = r_sync2[1];
  assign w_scl_prev = r_hist[0];
  assign w_sda_prev = r_hist[1];
  assign w_scl_rise = w_scl & ~w_scl_prev;
  assign w_scl_fall = ~w_scl & w_scl_prev;

  // START and STOP count only when SCL is high in both the current and the
  // previous sample. An SDA change that lands next to an SCL edge is then
  // treated as ordinary data, not as a bus condition.
  assign w_start = w_scl & w_scl_prev & w_sda_prev & ~w_sda;
  assign w_stop  = w_scl & w_scl_prev & ~w_sda_prev & w_sda;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t                   r_state;
  logic [3:0]               r_bit_cnt;  // bits received or sent in this byte
  logic [6:0]               r_shift;    // the previous 7 received bits
  logic [7:0]               r_tx;       // transmit shift register, MSB first
  logic                     r_phase;    // sub-step inside ACK, PTR and RDLOAD
  logic [1:0]               r_wait;     // short Clk delay counter
  logic                     r_rw_bit;   // R/W bit taken from the address byte
  logic                     r_en_pend;  // a write strobe is due on the next Clk
  logic                     r_sda_oe;
  logic                     r_enable;
  logic                     r_rorw;
  logic                     r_busy;
  logic [ADDRESSLENGTH-1:0] r_dir;
  logic [7:0]               r_inbuf;

  // The byte as it stands after the bit that is sampled on this SCL rise.
  logic [7:0] w_byte;
  logic       w_last_bit;

  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = w_scl_rise && (r_bit_cnt == 4'd7);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 7'd0;
      r_tx      <= 8'd0;
      r_phase   <= 1'b0;
      r_wait    <= 2'd0;
      r_rw_bit  <= 1'b0;
      r_en_pend <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_enable  <= 1'b0;
      r_rorw    <= 1'b0;
      r_busy    <= 1'b0;
      r_dir     <= '0;
      r_inbuf   <= 8'd0;
    end else begin
      // Enable is a single-Clk strobe. Any state that raises it must
      // request it again on every Clk it is wanted.
      r_enable <= 1'b0;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
        r_phase   <= 1'b0;
        r_en_pend <= 1'b0;
      end else if (w_start) begin
        // Covers a repeated START as well. The pointer is kept so that a
        // read that follows a pointer write uses that pointer.
        r_state   <= S_DEVADDR;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_bit_cnt <= 4'd0;
        r_phase   <= 1'b0;
        r_en_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
          end

          S_DEVADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              if (w_last_bit) begin
                r_bit_cnt <= 4'd0;
                r_rw_bit  <= w_sda;
                r_phase   <= 1'b0;
                r_state   <= (w_byte[7:1] == DEVADDR) ? S_DEVACK : S_WAITSTOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // phase 0: wait for the fall that ends bit 8, then pull SDA low.
          // phase 1 (read): after the master samples ACK, fetch the first
          //   byte. SDA stays low until RDDATA drives the first data bit.
          // phase 1 (write): release SDA on the fall and take the pointer.
          S_DEVACK: begin
            if (!r_phase) begin
              if (w_scl_fall) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 1'b1;
              end
            end else if (r_rw_bit) begin
              if (w_scl_rise) begin
                r_phase <= 1'b0;
                r_state <= S_RDLOAD;
              end
            end else if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_phase   <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_PTR;
            end
          end

          // The pointer is presented to the memory as soon as it is
          // complete. AddressFound is sampled only after the memory has had
          // two Clk to decode it. That is well inside the SCL high period.
          S_PTR: begin
            if (!r_phase) begin
              if (w_scl_rise) begin
                r_shift <= w_byte[6:0];
                if (w_last_bit) begin
                  r_dir     <= w_byte[ADDRESSLENGTH-1:0];
                  r_wait    <= 2'd2;
                  r_phase   <= 1'b1;
                  r_bit_cnt <= 4'd0;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                end
              end
            end else if (r_wait != 2'd0) begin
              r_wait <= r_wait - 2'd1;
            end else begin
              r_phase <= 1'b0;
              r_state <= AddressFound ? S_PTRACK : S_WAITSTOP;
            end
          end

          // ACK during a write: pull SDA low on the first fall and release it
          // on the second fall. The pending memory strobe in WRACK goes out
          // on the first Clk, before either fall can occur.
          S_PTRACK, S_WRACK: begin
            if (r_en_pend) begin
              r_enable  <= 1'b1;
              r_en_pend <= 1'b0;
            end
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_phase   <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_WRDATA;
              end
            end
          end

          S_WRDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              if (w_last_bit) begin
                r_inbuf   <= w_byte;
                r_rorw    <= 1'b1;
                r_en_pend <= 1'b1;
                r_bit_cnt <= 4'd0;
                r_phase   <= 1'b0;
                r_state   <= S_WRACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // Strobe a read and give the memory two Clk after the strobe
          // before OutputBuffer is captured. Entry happens on an SCL rise,
          // so the capture completes long before the fall on which the
          // first bit is driven.
          S_RDLOAD: begin
            if (!r_phase) begin
              r_enable <= 1'b1;
              r_rorw   <= 1'b0;
              r_wait   <= 2'd2;
              r_phase  <= 1'b1;
            end else if (r_wait != 2'd0) begin
              r_wait <= r_wait - 2'd1;
            end else begin
              r_tx      <= OutputBuffer;
              r_phase   <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_RDDATA;
            end
          end

          // Eight falls each put one bit on SDA. The ninth fall ends bit 0
          // and releases SDA so the master can ACK or NACK.
          S_RDDATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDACK;
              end else begin
                r_sda_oe  <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          S_RDACK: begin
            if (w_scl_rise) begin
              r_phase <= 1'b0;
              r_state <= w_sda ? S_WAITSTOP : S_RDLOAD;
            end
          end

          S_WAITSTOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SdaOe           = r_sda_oe;
  assign Enable          = r_enable;
  assign RorW            = r_rorw;
  assign Busy            = r_busy;
  assign DirectionBuffer = r_dir;
  assign InputBuffer     = r_inbuf;

endmodule

// File: tb/tb_i2c_slave_link.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_link
//
// This bench models an I2C master and a small read-data memory around
// i2c_slave_link. Stimulus tasks push the expected responses into queues.
// A single monitor process compares the following against those queues:
//   - bus responses the master observes (ACK bits and read bytes),
//   - status snapshots,
//   - memory strobes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_link;

  localparam int Q = 100;  // quarter of an SCL bit period, in ns

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       SclIn;
  logic       SdaIn;
  logic       SdaOe;
  logic       Enable;
  logic       RorW;
  logic [7:0] DirectionBuffer;
  logic [7:0] InputBuffer;
  logic [7:0] OutputBuffer;
  logic       AddressFound;
  logic       Busy;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic af    = 1'b1;
  logic [7:0] out_buf = 8'h00;

  // Open-drain bus: the line is low if either the master or the slave
  // pulls it low.
  assign SclIn        = scl_m;
  assign SdaIn        = sda_m & ~SdaOe;
  assign OutputBuffer = out_buf;
  assign AddressFound = af;

  i2c_slave_link #(.DEVADDR(7'h50), .ADDRESSLENGTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .SclIn(SclIn), .SdaIn(SdaIn), .SdaOe(SdaOe),
    .Enable(Enable), .RorW(RorW), .DirectionBuffer(DirectionBuffer),
    .InputBuffer(InputBuffer), .OutputBuffer(OutputBuffer),
    .AddressFound(AddressFound), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Scoreboard queues
  typedef struct packed {
    logic       rorw;
    logic [7:0] data;
    logic [7:0] ptr;
  } en_t;

  en_t         exp_en_q[$];
  string       exp_name_q[$];
  logic [15:0] exp_val_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  rd_data_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Memory read model: every read strobe returns the next queued byte.
  always @(posedge Clk) begin
    if (Enable && !RorW && rd_data_q.size() > 0)
      out_buf <= rd_data_q.pop_front();
  end

  // Monitor: the only process that compares values or counts results.
  initial begin
    logic        prev_en;
    en_t         e;
    logic [15:0] o;
    logic [15:0] x;
    string       n;
    prev_en = 1'b0;
    forever begin
      @(negedge Clk);
      if (Enable) begin
        n_cmp++;
        if (prev_en) begin
          n_err++;
          $display("FAIL en_back_to_back: got Enable high on two consecutive Clk, required single-Clk pulse");
        end
        if (exp_en_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_enable: got Enable=1 RorW=%b ptr=%h, required no transfer", RorW, DirectionBuffer);
        end else begin
          e = exp_en_q.pop_front();
          n_cmp++;
          if ({RorW, DirectionBuffer} !== {e.rorw, e.ptr} || (e.rorw && InputBuffer !== e.data)) begin
            n_err++;
            $display("FAIL enable_xfer: got RorW=%b ptr=%h data=%h, required RorW=%b ptr=%h data=%h",
                     RorW, DirectionBuffer, InputBuffer, e.rorw, e.ptr, e.data);
          end else begin
            $display("  xfer RorW=%b ptr=%h data=%h ok", RorW, DirectionBuffer, InputBuffer);
          end
        end
      end
      prev_en = Enable;

      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_val_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_obs: got %h, required nothing", o);
        end else begin
          n = exp_name_q.pop_front();
          x = exp_val_q.pop_front();
          if (o !== x) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", n, o, x);
          end else begin
            $display("  %s = %h ok", n, o);
          end
        end
      end
    end
  end

  // Stimulus helpers
  task automatic expect_val(input string n, input logic [15:0] v);
    exp_name_q.push_back(n);
    exp_val_q.push_back(v);
  endtask

  task automatic status(input string n, input logic [15:0] exp, input logic [15:0] act);
    expect_val(n, exp);
    obs_q.push_back(act);
  endtask

  task automatic expect_xfer(input logic rorw, input logic [7:0] data, input logic [7:0] ptr);
    en_t e;
    e.rorw = rorw;
    e.data = data;
    e.ptr  = ptr;
    exp_en_q.push_back(e);
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b;     #(Q);
    scl_m = 1'b1;  #(Q);
    s = SdaIn;     #(Q);
    scl_m = 1'b0;  #(Q);
  endtask

  task automatic do_start();
    sda_m = 1'b1;  #(Q);
    scl_m = 1'b1;  #(Q);
    sda_m = 1'b0;  #(Q);
    scl_m = 1'b0;  #(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;  #(Q);
    scl_m = 1'b1;  #(Q);
    sda_m = 1'b1;  #(Q);
  endtask

  task automatic write_byte(input string n, input logic [7:0] b, input logic exp_ack);
    logic s;
    expect_val(n, {15'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    obs_q.push_back({15'd0, s});
  endtask

  task automatic read_byte(input string n, input logic [7:0] exp_b, input logic m_ack);
    logic       s;
    logic [7:0] r;
    expect_val(n, {8'd0, exp_b});
    r = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      r[i] = s;
    end
    bit_io(m_ack, s);
    obs_q.push_back({8'd0, r});
  endtask

  // Watchdog
  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    logic s;

    // Reset state
    repeat (5) @(posedge Clk);
    #1;
    status("rst_sdaoe",  16'h0, {15'd0, SdaOe});
    status("rst_enable", 16'h0, {15'd0, Enable});
    status("rst_rorw",   16'h0, {15'd0, RorW});
    status("rst_busy",   16'h0, {15'd0, Busy});
    status("rst_dir",    16'h0, {8'd0, DirectionBuffer});
    status("rst_inbuf",  16'h0, {8'd0, InputBuffer});
    Reset = 1'b0;
    #(4*Q);

    // Write burst
    do_start();
    status("wr_busy", 16'h1, {15'd0, Busy});
    write_byte("wr_addr_ack", 8'hA0, 1'b0);
    write_byte("wr_ptr_ack",  8'h03, 1'b0);
    expect_xfer(1'b1, 8'h5A, 8'h03);
    write_byte("wr_d0_ack",   8'h5A, 1'b0);
    expect_xfer(1'b1, 8'hC3, 8'h03);
    write_byte("wr_d1_ack",   8'hC3, 1'b0);
    do_stop();
    #(Q);
    status("wr_dir",       16'h03, {8'd0, DirectionBuffer});
    status("wr_busy_stop", 16'h0,  {15'd0, Busy});

    // Read burst with repeated START
    rd_data_q.push_back(8'h5A);
    rd_data_q.push_back(8'hC3);
    do_start();
    write_byte("rd_addr_ack", 8'hA0, 1'b0);
    write_byte("rd_ptr_ack",  8'h03, 1'b0);
    expect_xfer(1'b0, 8'h00, 8'h03);
    expect_xfer(1'b0, 8'h00, 8'h03);
    do_start();
    write_byte("rd_addr_r_ack", 8'hA1, 1'b0);
    read_byte("rd_byte0", 8'h5A, 1'b0);
    read_byte("rd_byte1", 8'hC3, 1'b1);
    #(Q);
    status("rd_sda_released", 16'h0, {15'd0, SdaOe});
    do_stop();
    #(Q);
    status("rd_busy_stop", 16'h0, {15'd0, Busy});

    // Wrong device address
    do_start();
    write_byte("wa_addr_nack", 8'hA2, 1'b1);
    write_byte("wa_data_nack", 8'h11, 1'b1);
    status("wa_busy", 16'h1, {15'd0, Busy});
    do_stop();
    #(Q);
    status("wa_busy_stop", 16'h0, {15'd0, Busy});

    // Pointer rejected by memory
    af = 1'b0;
    do_start();
    write_byte("bp_addr_ack",  8'hA0, 1'b0);
    write_byte("bp_ptr_nack",  8'h77, 1'b1);
    write_byte("bp_data_nack", 8'h22, 1'b1);
    do_stop();
    #(Q);
    status("bp_busy_stop", 16'h0, {15'd0, Busy});
    af = 1'b1;

    // Reset during the 4th data bit of a write, then a fresh transaction
    do_start();
    write_byte("rs_addr_ack", 8'hA0, 1'b0);
    write_byte("rs_ptr_ack",  8'h03, 1'b0);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    sda_m = 1'b1;  #(Q);
    scl_m = 1'b1;  #(Q);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    status("rs_sdaoe",  16'h0, {15'd0, SdaOe});
    status("rs_enable", 16'h0, {15'd0, Enable});
    status("rs_busy",   16'h0, {15'd0, Busy});
    status("rs_dir",    16'h0, {8'd0, DirectionBuffer});
    scl_m = 1'b0;  #(Q);
    sda_m = 1'b1;  #(Q);
    scl_m = 1'b1;  #(Q);
    Reset = 1'b0;  #(Q);
    status("rs_idle_busy", 16'h0, {15'd0, Busy});
    do_start();
    write_byte("rs2_addr_ack", 8'hA0, 1'b0);
    write_byte("rs2_ptr_ack",  8'h05, 1'b0);
    expect_xfer(1'b1, 8'h3C, 8'h05);
    write_byte("rs2_d0_ack",   8'h3C, 1'b0);
    do_stop();
    #(Q);
    status("rs2_dir", 16'h05, {8'd0, DirectionBuffer});

    // STOP after 3 bits of a data byte
    do_start();
    write_byte("es_addr_ack", 8'hA0, 1'b0);
    write_byte("es_ptr_ack",  8'h03, 1'b0);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    do_stop();
    #(Q);
    status("es_busy",  16'h0, {15'd0, Busy});
    status("es_sdaoe", 16'h0, {15'd0, SdaOe});

    // Every expected memory strobe must have been seen.
    #(4*Q);
    status("en_leftover", 16'h0, exp_en_q.size()[15:0]);
    repeat (4) @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
